// File: rtl/vmon_m2h_pkg.sv
// ============================================================================
// vmon_m2h_pkg : shared types, constants and header builder for vmon_m2h_arb
// Rev 1.0
// ============================================================================
`default_nettype none

package vmon_m2h_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [3:0] c_hdr_tag = 4'hA;

    // Header byte: tag nibble over the granted source index.
    function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [3:0] idx);
        return {tag, idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vmon_m2h_arb_if.sv
// ============================================================================
// vmon_m2h_arb_if : source byte streams and m2h output stream of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface vmon_m2h_arb_if #(
    parameter int N_SRC = 4,
    parameter int DW    = 8
);
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC*DW-1:0] src_data;
    logic [N_SRC-1:0]    src_last;
    logic [N_SRC-1:0]    src_ready;
    logic                m2h_valid;
    logic [DW-1:0]       m2h_data;
    logic                m2h_last;
    logic                m2h_ready;

    modport slave (
        input  src_valid, src_data, src_last, m2h_ready,
        output src_ready, m2h_valid, m2h_data, m2h_last
    );

    modport master (
        output src_valid, src_data, src_last, m2h_ready,
        input  src_ready, m2h_valid, m2h_data, m2h_last
    );
endinterface

`default_nettype wire

// File: rtl/vmon_rr_pick.sv
// ============================================================================
// vmon_rr_pick : round-robin picker, first request searching from last+1
// Rev 1.0
// ============================================================================
`default_nettype none

module vmon_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [IW-1:0] last,
    output logic      [IW-1:0] grant,
    output logic               any
);
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            // Modulo by single conditional subtract: last < N and k <= N.
            sum = {1'b0, last} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/vmon_m2h_arb.sv
// ============================================================================
// vmon_m2h_arb : frames per-source monitor messages onto one m2h byte stream
// Rev 1.0
// ============================================================================
`default_nettype none

module vmon_m2h_arb
    import vmon_m2h_pkg::*;
#(
    parameter int         N_SRC   = 4,
    parameter int         DW      = 8,
    parameter logic [3:0] HDR_TAG = c_hdr_tag
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    input  wire logic       en,
    vmon_m2h_arb_if.slave   bus,
    output logic            busy,
    output logic [15:0]     pkt_count
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [15:0]   pkt_count_q, pkt_count_d;

    logic [IW-1:0]    w_pick;
    logic             w_any;
    logic             w_sel_valid;
    logic [DW-1:0]    w_sel_data;
    logic             w_sel_last;
    logic             w_m2h_valid;
    logic [DW-1:0]    w_m2h_data;
    logic             w_m2h_last;
    logic [N_SRC-1:0] w_src_ready;

    vmon_rr_pick #(
        .N  (N_SRC),
        .IW (IW)
    ) u_pick (
        .req   (bus.src_valid),
        .last  (last_grant_q),
        .grant (w_pick),
        .any   (w_any)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == IW'(i)) begin
                w_sel_valid = bus.src_valid[i];
                w_sel_data  = bus.src_data[i*DW +: DW];
                w_sel_last  = bus.src_last[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_count_d  = pkt_count_q;
        w_m2h_valid  = 1'b0;
        w_m2h_data   = '0;
        w_m2h_last   = 1'b0;
        w_src_ready  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (en && w_any) begin
                    grant_d = w_pick;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                w_m2h_valid = 1'b1;
                w_m2h_data  = DW'(hdr_byte(HDR_TAG, 4'(grant_q)));
                if (bus.m2h_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Pass-through of the granted source; others stay stalled.
                w_m2h_valid = w_sel_valid;
                w_m2h_data  = w_sel_data;
                w_m2h_last  = w_sel_last;
                for (int i = 0; i < N_SRC; i++) begin
                    if (grant_q == IW'(i)) begin
                        w_src_ready[i] = bus.m2h_ready;
                    end
                end
                if (w_sel_valid && bus.m2h_ready && w_sel_last) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                    pkt_count_d  = pkt_count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(N_SRC - 1);
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign bus.m2h_valid = w_m2h_valid;
    assign bus.m2h_data  = w_m2h_data;
    assign bus.m2h_last  = w_m2h_last;
    assign bus.src_ready = w_src_ready;
    assign busy          = (state_q != ST_IDLE);
    assign pkt_count     = pkt_count_q;
endmodule

`default_nettype wire

// File: tb/tb_vmon_m2h_arb.sv
// ============================================================================
// tb_vmon_m2h_arb : directed scoreboard bench for vmon_m2h_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vmon_m2h_arb;
    logic        clk;
    logic        rstn;
    logic        en;
    logic        busy;
    logic [15:0] pkt_count;

    vmon_m2h_arb_if #(.N_SRC(4), .DW(8)) bus ();

    vmon_m2h_arb #(.N_SRC(4), .DW(8), .HDR_TAG(4'hA)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .bus       (bus),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pop    = 0;

    logic [8:0] exp_q[$];

    // Per-source message memories: {last, byte}.
    logic [8:0] mem [4][32];
    int         wr_p [4];
    int         rd_p [4];
    logic       hs   [4];
    logic       tgl;
    logic       rdy_lvl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic load(input int s, input logic [7:0] b, input logic l);
        mem[s][wr_p[s] % 32] = {l, b};
        wr_p[s]++;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (n_pop < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n_pop < target) chk("pop_timeout", 32'(n_pop), 32'(target));
    endtask

    // Source model and m2h_ready driver: update just after each rising edge.
    initial begin
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.src_last  = '0;
        bus.m2h_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_p[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!rstn) rd_p[i] = wr_p[i];
                else if (hs[i]) rd_p[i]++;
                bus.src_valid[i]      = (rd_p[i] != wr_p[i]);
                bus.src_data[i*8 +: 8] = mem[i][rd_p[i] % 32][7:0];
                bus.src_last[i]       = mem[i][rd_p[i] % 32][8];
            end
            bus.m2h_ready = tgl ? ~bus.m2h_ready : rdy_lvl;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            hs[i] = bus.src_valid[i] & bus.src_ready[i];
        end
    end

    // Monitor: compare each accepted m2h byte against the scoreboard.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out   = '0;
    logic [8:0] got;
    logic [8:0] want;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else if (bus.m2h_valid) begin
            got = {bus.m2h_last, bus.m2h_data};
            if (prev_stall) chk("stall_stable", 32'(got), 32'(prev_out));
            if (bus.m2h_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(got), 32'h1ff);
                end else begin
                    want = exp_q.pop_front();
                    chk("m2h_byte", 32'(got), 32'(want));
                end
                n_pop++;
            end
            prev_stall = !bus.m2h_ready;
            prev_out   = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        for (int i = 0; i < 4; i++) begin
            wr_p[i] = 0;
            hs[i]   = 1'b0;
        end
        tgl     = 1'b0;
        rdy_lvl = 1'b1;
        en      = 1'b1;
        rstn    = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_m2h_valid", 32'(bus.m2h_valid), 32'd0);
        chk("rst_m2h_data",  32'(bus.m2h_data),  32'd0);
        chk("rst_m2h_last",  32'(bus.m2h_last),  32'd0);
        chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_pkt_count", 32'(pkt_count),     32'd0);
        rstn = 1'b1;

        // Source 2 three-byte message.
        load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h33, 1'b1);
        exp_q.push_back(9'h0A2); exp_q.push_back(9'h011);
        exp_q.push_back(9'h022); exp_q.push_back(9'h133);
        wait_empty("single_src", 100);
        settle();
        chk("pkt_count_single", 32'(pkt_count), 32'd1);
        chk("busy_after_single", 32'(busy), 32'd0);

        // Fresh reset, all four sources with two single-byte messages each.
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                load(i, 8'(16 * (m + 1) + i), 1'b1);
            end
        end
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back({1'b0, 4'hA, 4'(i)});
                exp_q.push_back({1'b1, 8'(16 * (m + 1) + i)});
            end
        end
        wait_empty("rr_all", 200);
        settle();
        chk("pkt_count_rr", 32'(pkt_count), 32'd8);

        // Four-byte packet from source 1 with m2h_ready toggling.
        tgl = 1'b1;
        load(1, 8'h31, 1'b0); load(1, 8'h32, 1'b0); load(1, 8'h33, 1'b0); load(1, 8'h34, 1'b1);
        exp_q.push_back(9'h0A1); exp_q.push_back(9'h031); exp_q.push_back(9'h032);
        exp_q.push_back(9'h033); exp_q.push_back(9'h134);
        wait_empty("toggle", 200);
        tgl = 1'b0;
        settle();
        chk("pkt_count_toggle", 32'(pkt_count), 32'd9);

        // en dropped mid-packet: packet finishes, pending source 3 waits.
        load(1, 8'h41, 1'b0); load(1, 8'h42, 1'b0); load(1, 8'h43, 1'b1);
        exp_q.push_back(9'h0A1); exp_q.push_back(9'h041);
        exp_q.push_back(9'h042); exp_q.push_back(9'h143);
        base = n_pop;
        wait_pops(base + 2, 100);
        en = 1'b0;
        load(3, 8'h51, 1'b1);
        wait_empty("en_low", 100);
        repeat (10) @(posedge clk);
        #2;
        chk("en_low_busy", 32'(busy), 32'd0);
        chk("en_low_valid", 32'(bus.m2h_valid), 32'd0);
        chk("pkt_count_en_low", 32'(pkt_count), 32'd10);
        exp_q.push_back(9'h0A3); exp_q.push_back(9'h151);
        en = 1'b1;
        wait_empty("en_high", 100);
        settle();
        chk("pkt_count_en_high", 32'(pkt_count), 32'd11);

        // Reset while source 2's second data byte is on the bus.
        load(2, 8'h61, 1'b0); load(2, 8'h62, 1'b0); load(2, 8'h63, 1'b1);
        exp_q.push_back(9'h0A2); exp_q.push_back(9'h061);
        base = n_pop;
        wait_pops(base + 2, 100);
        @(posedge clk);
        #3;
        chk("pre_rst_valid", 32'(bus.m2h_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.m2h_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
        chk("midrst_src_ready", 32'(bus.src_ready), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        load(3, 8'h71, 1'b1);
        load(0, 8'h70, 1'b1);
        exp_q.push_back(9'h0A0); exp_q.push_back(9'h170);
        exp_q.push_back(9'h0A3); exp_q.push_back(9'h171);
        wait_empty("after_rst", 100);
        settle();
        chk("pkt_count_after_rst", 32'(pkt_count), 32'd2);

        // Counter wrap from 16'hFFFF.
        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        release dut.pkt_count_q;
        #1;
        chk("pkt_count_preload", 32'(pkt_count), 32'h0000FFFF);
        load(1, 8'h81, 1'b1);
        exp_q.push_back(9'h0A1); exp_q.push_back(9'h181);
        wait_empty("wrap", 100);
        settle();
        chk("pkt_count_wrap", 32'(pkt_count), 32'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/vmon_m2h_arb.md
VMON_M2H_ARB -- requirements
Module: vmon_m2h_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning number of monitor message sources (2..16).
REQ-002 SHALL have parameter DW, default 8, meaning byte-stream data width on every port.
REQ-003 SHALL have parameter HDR_TAG, default 4'hA, meaning upper nibble of the packet header byte.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port en  input  1  enables new grants.
REQ-007 SHALL have port src_valid  input  N_SRC  per-source byte valid.
REQ-008 SHALL have port src_data  input  N_SRC*DW  per-source byte; source i occupies bits [i*DW +: DW].
REQ-009 SHALL have port src_last  input  N_SRC  per-source final byte of message.
REQ-010 SHALL have port src_ready  output  N_SRC  per-source accept.
REQ-011 SHALL have port m2h_valid  output  1  m2h byte valid.
REQ-012 SHALL have port m2h_data  output  DW  m2h byte.
REQ-013 SHALL have port m2h_last  output  1  final byte of framed packet.
REQ-014 SHALL have port m2h_ready  input  1  m2h path accepts byte.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port pkt_count  output  16  completed packets, wraps 16'hFFFF->0.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, HDR, DATA.
REQ-018 IDLE: when en=1 and any src_valid=1, SHALL register grant = first valid source searching round-robin from (last_grant+1) mod N_SRC, then go to HDR next cycle.
REQ-019 IDLE: m2h_valid=0 and src_ready=0 for all sources.
REQ-020 HDR: m2h_valid=1, m2h_data={HDR_TAG, grant[3:0]} (zero-extended/truncated to DW), m2h_last=0; all src_ready=0; on m2h_ready=1, go to DATA.
REQ-021 DATA: m2h_valid=src_valid[grant], m2h_data=src_data[grant], m2h_last=src_last[grant], src_ready[grant]=m2h_ready, other src_ready=0; combinational pass-through, zero added latency.
REQ-022 DATA: on a handshake with src_last[grant]=1, SHALL go to IDLE, set last_grant=grant, and increment pkt_count in the same edge.
REQ-023 Grant SHALL be locked from HDR until that last handshake; other sources' valids SHALL be ignored during this time.
REQ-024 Deasserting en SHALL block only new grants; a packet in HDR or DATA SHALL complete normally.
REQ-025 The minimum per-packet overhead SHALL be one IDLE cycle plus one HDR cycle; back-to-back packets SHALL never merge.
REQ-026 A grant SHALL never be issued to a source whose src_valid is 0 in the IDLE decision cycle.
REQ-027 Single-byte message (src_last on first byte): output SHALL be HDR, then one DATA byte with m2h_last=1.
REQ-028 m2h_data and m2h_last SHALL be held stable while m2h_valid=1 and m2h_ready=0 (HDR registered; DATA relies on source stability).

Reset
REQ-029 On rstn=0, state SHALL go to IDLE asynchronously, grant=0, last_grant=N_SRC-1 (so source 0 wins first), and pkt_count=0.
REQ-030 During reset, outputs SHALL be m2h_valid=0, m2h_last=0, m2h_data=0, src_ready=0, and busy=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet without incrementing pkt_count; after release, arbitration SHALL restart from source 0.

Structure
REQ-032 The FSM state enum, header-tag constant and header-byte build function SHALL live in shared package vmon_m2h_pkg.
REQ-033 The round-robin priority picker SHALL be a separate sub-module, vmon_rr_pick (inputs req, last; output grant index, any).
REQ-034 Target size SHALL be 150-300 lines RTL.

Verification
REQ-035 Single source 2, 3-byte msg 11,22,33, m2h_ready=1 -> output A2,11,22,33, last on 33, pkt_count=1.
REQ-036 All 4 sources continuously valid with 1-byte msgs -> header order A0,A1,A2,A3,A0; each packet is 2 bytes.
REQ-037 m2h_ready toggled 0/1 every cycle during 4-byte packet -> no byte lost or duplicated; data stable while stalled.
REQ-038 en=0 mid-DATA of source 1 -> packet completes; no further HDR while en=0 despite pending src 3; en=1 -> A3 issued.
REQ-039 rstn pulsed low during DATA byte 2 -> m2h_valid=0 immediately, pkt_count=0, next grant is source 0.
REQ-040 Preload pkt_count to 16'hFFFF by 65535 packets, send 1 more packet -> pkt_count=0.
